spi_flash_reader: RTL and testbench

//  SPI mode-0 master that fetches one 32-bit word from the SoC SPI NOR flash model
//  per request, using only the 03h Read Data command.

---
 rtl/spi_flash_reader.sv | 144 ++++++++++++++
 tb/tb_spi_flash_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 master issuing one 03h Read Data per request and returning a 32-bit word.
// Latency: accept-to-resp_valid = 1 + 128*CLK_DIV cycles; back-to-back spacing = latency + 1 + SS_GAP.
// Backpressure: req_ready only in IDLE; resp_valid/resp_data held stable until resp_ready.
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   req_valid/req_ready    request handshake, req_addr = 24-bit flash byte address
//   resp_valid/resp_ready  response handshake, resp_data = {b3,b2,b1,b0}, b0 first byte on the wire
//   sck, ss, mosi, miso    SPI pins (sck idles low, ss active low, MSB first)
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int SS_GAP  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(SS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP,
    GAP
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        shift_out_q, shift_out_d;
  logic [31:0]        shift_in_q, shift_in_d;
  logic [6:0]         bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               sck_q, sck_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_out_q <= '0;
      shift_in_q  <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      sck_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      sck_q       <= sck_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    bit_d       = bit_q;
    div_d       = div_q;
    gap_d       = gap_q;
    sck_d       = sck_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          shift_out_d = {8'h03, req_addr, 32'h0};
          bit_d       = '0;
          div_d       = '0;
          sck_d       = 1'b0;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            // Rising edge: only the second half of the frame (bits 32..63) carries read data.
            sck_d = 1'b1;
            if (bit_q[5]) begin
              shift_in_d = {shift_in_q[30:0], miso};
            end
          end else begin
            // Falling edge: advance mosi so it settles while sck is low.
            sck_d       = 1'b0;
            shift_out_d = {shift_out_q[62:0], 1'b0};
            if (bit_q == 7'd63) begin
              gap_d   = '0;
              state_d = RESP;
            end else begin
              bit_d = bit_q + 7'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      RESP: begin
        // The ss-high gap starts counting as soon as ss rises, so a slow consumer
        // absorbs part or all of it.
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end
        if (resp_ready) begin
          state_d = GAP;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign ss         = (state_q != SHIFT);
  assign sck        = sck_q;
  assign mosi       = (state_q == SHIFT) && shift_out_q[63];
  // First byte received sits in shift_in_q[31:24]; it becomes the low byte.
  assign resp_data  = {shift_in_q[7:0], shift_in_q[15:8], shift_in_q[23:16], shift_in_q[31:24]};

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1), each paired with a
// behavioural SPI NOR flash model answering the 03h command from a shared byte image.
// Expected words come from the image with plain little-endian byte arithmetic.
module tb_spi_flash_reader;

  localparam int SS_GAP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = '0;
  logic [1:0]  sck;
  logic [1:0]  ss;
  logic [1:0]  mosi;
  logic [23:0] req_addr [2];
  logic [31:0] resp_data [2];

  logic [7:0]  mem [256];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          t_acc, t_rv, t_hs, h1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : u
    logic        miso_s = 1'b0;
    int          fbits = 0;
    int          done_bits = 0;
    int          k;
    logic [31:0] cmd = '0;
    logic [31:0] last_cmd = '0;
    logic [23:0] ba;
    logic [7:0]  bv;
    longint      prev_t = 0;
    longint      min_p = 64'd1000000;
    longint      max_p = 0;

    spi_flash_reader #(.CLK_DIV(g == 0 ? 2 : 1), .SS_GAP(SS_GAP)) dut (
      .clock      (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .sck        (sck[g]),
      .ss         (ss[g]),
      .mosi       (mosi[g]),
      .miso       (miso_s)
    );

    // Flash model: command/address sampled on rising sck, data driven on falling sck.
    always @(posedge sck[g] or negedge sck[g] or posedge ss[g]) begin
      if (ss[g]) begin
        if (fbits > 0) begin
          done_bits = fbits;
          last_cmd  = cmd;
        end
        fbits  = 0;
        prev_t = 0;
        miso_s = 1'b0;
      end else if (sck[g]) begin
        if (fbits < 32) cmd = {cmd[30:0], mosi[g]};
        fbits++;
        if (prev_t != 0) begin
          if ($time - prev_t < min_p) min_p = $time - prev_t;
          if ($time - prev_t > max_p) max_p = $time - prev_t;
        end
        prev_t = $time;
      end else if (fbits >= 32) begin
        k      = fbits - 32;
        ba     = cmd[23:0] + 24'(k / 8);
        bv     = mem[ba[7:0]];
        miso_s = bv[7 - (k % 8)];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [7:0]  b [4];
    logic [23:0] ai;
    for (int i = 0; i < 4; i++) begin
      ai   = a + 24'(i);
      b[i] = mem[ai[7:0]];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Called and returns at a negedge. keep=1 leaves req_valid high for a following request.
  task automatic do_read(input int g, input logic [23:0] a, input int hold, input bit keep);
    int n;
    req_addr[g]  = a;
    req_valid[g] = 1'b1;
    n = 0;
    while (!req_ready[g] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept", 64'(req_ready[g]), 64'd1);
    t_acc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!keep) req_valid[g] = 1'b0;
    end while (!resp_valid[g] && n < 2000);
    check("resp_valid", 64'(resp_valid[g]), 64'd1);
    t_rv = cyc;
    check("resp_data", 64'(resp_data[g]), 64'(exp_word(a)));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid[g]), 64'd1);
      check("hold_data", 64'(resp_data[g]), 64'(exp_word(a)));
      check("hold_ss", 64'(ss[g]), 64'd1);
      check("hold_req_ready", 64'(req_ready[g]), 64'd0);
    end
    resp_ready[g] = 1'b1;
    t_hs = cyc;
    @(negedge clk);
    resp_ready[g] = 1'b0;
    check("resp_drop", 64'(resp_valid[g]), 64'd0);
    check("gap_req_ready", 64'(req_ready[g]), 64'd0);
    check("gap_ss", 64'(ss[g]), 64'd1);
  endtask

  initial begin
    int n;
    int g;
    int lat;
    logic [23:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h44; mem[1] = 8'h33; mem[2] = 8'h22; mem[3] = 8'h11;
    req_addr[0] = '0;
    req_addr[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ss", 64'(ss[0]), 64'd1);
    check("rst_sck", 64'(sck[0]), 64'd0);
    check("rst_mosi", 64'(mosi[0]), 64'd0);
    check("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
    check("rst_resp_data", 64'(resp_data[0]), 64'd0);
    check("rst_req_ready", 64'(req_ready[0]), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // 1: read 0x000000
    do_read(0, 24'h000000, 0, 1'b0);
    check("lat_div2", 64'(t_rv - t_acc), 64'd257);
    check("cmd_addr0", 64'(u[0].last_cmd), 64'h03000000);
    check("sck_rises", 64'(u[0].done_bits), 64'd64);
    check("word0", 64'(resp_data[0]), 64'h11223344);

    // 2: back-to-back with req_valid held
    do_read(0, 24'h000000, 0, 1'b1);
    h1 = t_hs;
    do_read(0, 24'h000004, 0, 1'b0);
    check("b2b_spacing", 64'(t_acc - h1), 64'(1 + SS_GAP));

    // 3: consumer stalls 20 cycles
    a = 24'($urandom);
    do_read(0, a, 20, 1'b0);
    n = 0;
    while (!req_ready[0] && n < SS_GAP) begin
      @(negedge clk);
      n++;
    end
    check("stall_gap_done", 64'(req_ready[0]), 64'd1);

    // 4: reset during bit 40
    req_addr[0]  = '0;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (u[0].fbits < 40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_bit40", 64'(u[0].fbits >= 40), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_sck", 64'(sck[0]), 64'd0);
    check("abort_ss", 64'(ss[0]), 64'd1);
    check("abort_resp_valid", 64'(resp_valid[0]), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_resp", 64'(resp_valid[0]), 64'd0);
    do_read(0, 24'h000000, 0, 1'b0);
    check("after_abort_lat", 64'(t_rv - t_acc), 64'd257);

    // 5: CLK_DIV=1, addr 0xABCDEF
    do_read(1, 24'hABCDEF, 0, 1'b0);
    check("lat_div1", 64'(t_rv - t_acc), 64'd129);
    check("cmd_abcdef", 64'(u[1].last_cmd), 64'h03ABCDEF);
    check("sck_rises_div1", 64'(u[1].done_bits), 64'd64);
    check("sck_period_min_div1", 64'(u[1].min_p), 64'd20);
    check("sck_period_max_div1", 64'(u[1].max_p), 64'd20);
    check("sck_period_min_div2", 64'(u[0].min_p), 64'd40);
    check("sck_period_max_div2", 64'(u[0].max_p), 64'd40);

    // 6: unaligned
    do_read(0, 24'h000001, 0, 1'b0);
    check("cmd_unaligned", 64'(u[0].last_cmd), 64'h03000001);

    // Random addresses on both instances
    for (int i = 0; i < 6; i++) begin
      g   = int'($urandom_range(0, 1));
      a   = 24'($urandom);
      lat = (g == 0) ? 257 : 129;
      do_read(g, a, int'($urandom_range(0, 3)), 1'b0);
      check("rand_lat", 64'(t_rv - t_acc), 64'(lat));
      check("rand_cmd", 64'(g == 0 ? u[0].last_cmd : u[1].last_cmd), {32'h0, 8'h03, a});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
